// File: rtl/mem_arbiter.sv
// Round-robin arbiter that serialises block read/write requests from N_REQ
// requesters onto one block memory and returns one response at a time.
module mem_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DEPTH      = 1024,
  parameter int SIZE       = 32,
  parameter int BLOCK_SIZE = 5,
  parameter int ADDR_SIZE  = 24
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [N_REQ-1:0]                    i_req_valid,
  output logic [N_REQ-1:0]                    o_req_ready,
  input  logic [N_REQ-1:0]                    i_req_we,
  input  logic [N_REQ*ADDR_SIZE-1:0]          i_req_addr,
  input  logic [N_REQ*SIZE*BLOCK_SIZE-1:0]    i_req_data,
  input  logic [N_REQ*$clog2(BLOCK_SIZE)-1:0] i_req_size,
  output logic [N_REQ-1:0]                    o_rsp_valid,
  input  logic [N_REQ-1:0]                    i_rsp_ready,
  output logic [SIZE*BLOCK_SIZE-1:0]          o_rsp_data,
  output logic                                o_rsp_err,
  output logic [ADDR_SIZE-1:0]                o_mem_addr_w,
  output logic [SIZE*BLOCK_SIZE-1:0]          o_mem_data_w,
  output logic [$clog2(BLOCK_SIZE)-1:0]       o_mem_wr_size,
  output logic                                o_mem_wr_en,
  output logic [ADDR_SIZE-1:0]                o_mem_addr_r,
  input  logic [SIZE*BLOCK_SIZE-1:0]          i_mem_data
);

  localparam int DW  = SIZE * BLOCK_SIZE;
  localparam int SW  = $clog2(BLOCK_SIZE);
  localparam int IDW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       ptr_q;
  logic [IDW-1:0]       id_q;
  logic                 we_q;
  logic                 ok_q;

  logic [ADDR_SIZE-1:0] mem_addr_w_q;
  logic [DW-1:0]        mem_data_w_q;
  logic [SW-1:0]        mem_wr_size_q;
  logic                 mem_wr_en_q;
  logic [ADDR_SIZE-1:0] mem_addr_r_q;

  logic [N_REQ-1:0]     rsp_valid_q;
  logic [DW-1:0]        rsp_data_q;
  logic                 rsp_err_q;

  logic                 grant_found;
  logic [IDW-1:0]       grant_idx;
  logic                 sel_we;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [DW-1:0]        sel_data;
  logic [SW-1:0]        sel_size_raw;
  logic [SW-1:0]        sel_size;
  logic [ADDR_SIZE:0]   sel_end;
  logic                 sel_ok;

  // Search starts one past the last winner so every waiting requester is
  // served before anyone gets a second turn.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!grant_found && i_req_valid[(int'(ptr_q) + i) % N_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'((int'(ptr_q) + i) % N_REQ);
      end
    end
  end

  assign sel_we       = i_req_we[grant_idx];
  assign sel_addr     = i_req_addr[grant_idx*ADDR_SIZE +: ADDR_SIZE];
  assign sel_data     = i_req_data[grant_idx*DW +: DW];
  assign sel_size_raw = i_req_size[grant_idx*SW +: SW];
  assign sel_size     = (sel_size_raw > SW'(BLOCK_SIZE)) ? SW'(BLOCK_SIZE) : sel_size_raw;

  // One extra bit so addr + length cannot wrap past the top of the address space.
  assign sel_end = {1'b0, sel_addr} +
                   (sel_we ? (ADDR_SIZE+1)'(sel_size) : (ADDR_SIZE+1)'(BLOCK_SIZE));
  assign sel_ok  = (sel_end <= (ADDR_SIZE+1)'(DEPTH));

  assign o_req_ready = (state_q == IDLE && grant_found && !i_rst)
                       ? (N_REQ'(1) << grant_idx) : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_found) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    if (i_rsp_ready[id_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (i_rst) begin
      state_q       <= IDLE;
      ptr_q         <= IDW'(N_REQ - 1);
      id_q          <= '0;
      we_q          <= 1'b0;
      ok_q          <= 1'b0;
      mem_addr_w_q  <= '0;
      mem_data_w_q  <= '0;
      mem_wr_size_q <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_addr_r_q  <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_wr_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            ptr_q <= grant_idx;
            id_q  <= grant_idx;
            we_q  <= sel_we;
            ok_q  <= sel_ok;
            // Memory ports are loaded on accept so they are valid for the ISSUE cycle.
            if (sel_we && sel_ok && sel_size != '0) begin
              mem_wr_en_q   <= 1'b1;
              mem_addr_w_q  <= sel_addr;
              mem_data_w_q  <= sel_data;
              mem_wr_size_q <= sel_size;
            end else if (!sel_we && sel_ok) begin
              mem_addr_r_q <= sel_addr;
            end
          end
        end
        ISSUE: begin
          rsp_valid_q <= N_REQ'(1) << id_q;
          rsp_err_q   <= !ok_q;
          rsp_data_q  <= (!we_q && ok_q) ? i_mem_data : '0;
        end
        RESP: begin
          if (i_rsp_ready[id_q]) begin
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_data    = rsp_data_q;
  assign o_rsp_err     = rsp_err_q;
  assign o_mem_addr_w  = mem_addr_w_q;
  assign o_mem_data_w  = mem_data_w_q;
  assign o_mem_wr_size = mem_wr_size_q;
  assign o_mem_addr_r  = mem_addr_r_q;
  // Reset arriving during ISSUE must suppress the write already on the port.
  assign o_mem_wr_en   = mem_wr_en_q && !i_rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single transactions plus
// hand-written sequences for fairness, backpressure and mid-op reset.
module tb_mem_arbiter;

  localparam int N_REQ      = 4;
  localparam int DEPTH      = 1024;
  localparam int SIZE       = 32;
  localparam int BLOCK_SIZE = 5;
  localparam int ADDR_SIZE  = 24;
  localparam int DW         = SIZE * BLOCK_SIZE;
  localparam int SW         = $clog2(BLOCK_SIZE);

  logic                       i_clk = 1'b0;
  logic                       i_rst = 1'b1;
  logic [N_REQ-1:0]           i_req_valid = '0;
  logic [N_REQ-1:0]           o_req_ready;
  logic [N_REQ-1:0]           i_req_we = '0;
  logic [N_REQ*ADDR_SIZE-1:0] i_req_addr = '0;
  logic [N_REQ*DW-1:0]        i_req_data = '0;
  logic [N_REQ*SW-1:0]        i_req_size = '0;
  logic [N_REQ-1:0]           o_rsp_valid;
  logic [N_REQ-1:0]           i_rsp_ready = '0;
  logic [DW-1:0]              o_rsp_data;
  logic                       o_rsp_err;
  logic [ADDR_SIZE-1:0]       o_mem_addr_w;
  logic [DW-1:0]              o_mem_data_w;
  logic [SW-1:0]              o_mem_wr_size;
  logic                       o_mem_wr_en;
  logic [ADDR_SIZE-1:0]       o_mem_addr_r;
  logic [DW-1:0]              i_mem_data;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(
    .N_REQ(N_REQ), .DEPTH(DEPTH), .SIZE(SIZE),
    .BLOCK_SIZE(BLOCK_SIZE), .ADDR_SIZE(ADDR_SIZE)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_addr(i_req_addr),
    .i_req_data(i_req_data), .i_req_size(i_req_size),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .o_mem_addr_w(o_mem_addr_w), .o_mem_data_w(o_mem_data_w),
    .o_mem_wr_size(o_mem_wr_size), .o_mem_wr_en(o_mem_wr_en),
    .o_mem_addr_r(o_mem_addr_r), .i_mem_data(i_mem_data)
  );

  always #5 i_clk = ~i_clk;

  // Block memory model: synchronous partial write, combinational block read.
  logic [SIZE-1:0] mem [DEPTH] = '{default: '0};

  always @(posedge i_clk) begin
    if (o_mem_wr_en) begin
      for (int j = 0; j < int'(o_mem_wr_size); j++)
        if (int'(o_mem_addr_w) + j < DEPTH)
          mem[int'(o_mem_addr_w) + j] <= o_mem_data_w[(BLOCK_SIZE-1-j)*SIZE +: SIZE];
    end
  end

  always_comb begin
    i_mem_data = '0;
    for (int j = 0; j < BLOCK_SIZE; j++)
      if (int'(o_mem_addr_r) + j < DEPTH)
        i_mem_data[(BLOCK_SIZE-1-j)*SIZE +: SIZE] = mem[int'(o_mem_addr_r) + j];
  end

  function automatic logic [DW-1:0] blk(input logic [SIZE-1:0] seed);
    logic [DW-1:0] r;
    for (int j = 0; j < BLOCK_SIZE; j++)
      r[(BLOCK_SIZE-1-j)*SIZE +: SIZE] = seed + SIZE'(j);
    return r;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int id, input logic we, input logic [ADDR_SIZE-1:0] addr,
                         input logic [SW-1:0] size, input logic [DW-1:0] data);
    i_req_we[id] = we;
    i_req_addr[id*ADDR_SIZE +: ADDR_SIZE] = addr;
    i_req_size[id*SW +: SW] = size;
    i_req_data[id*DW +: DW] = data;
  endtask

  typedef struct {
    int                   id;
    logic                 we;
    logic [ADDR_SIZE-1:0] addr;
    logic [SW-1:0]        size;
    logic [SIZE-1:0]      seed;
    logic                 exp_err;
    logic                 exp_wr;
    logic [SW-1:0]        exp_wsize;
    logic                 chk_ar;
    logic [ADDR_SIZE-1:0] exp_ar;
    logic [DW-1:0]        exp_data;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  task automatic run_vec(input vec_t v);
    logic [N_REQ-1:0] oh;
    oh = N_REQ'(1) << v.id;
    @(negedge i_clk);
    set_req(v.id, v.we, v.addr, v.size, blk(v.seed));
    i_req_valid = oh;
    #1;
    check("vec_req_ready", DW'(o_req_ready), DW'(oh));
    @(posedge i_clk); #1;
    i_req_valid = '0;
    check("issue_wr_en", DW'(o_mem_wr_en), DW'(v.exp_wr));
    if (v.exp_wr) begin
      check("issue_wr_size", DW'(o_mem_wr_size), DW'(v.exp_wsize));
      check("issue_addr_w", DW'(o_mem_addr_w), DW'(v.addr));
      check("issue_data_w", o_mem_data_w, blk(v.seed));
    end
    if (v.chk_ar) check("issue_addr_r", DW'(o_mem_addr_r), DW'(v.exp_ar));
    check("issue_rsp_valid", DW'(o_rsp_valid), '0);
    @(posedge i_clk); #1;
    check("resp_valid", DW'(o_rsp_valid), DW'(oh));
    check("resp_err", DW'(o_rsp_err), DW'(v.exp_err));
    check("resp_data", o_rsp_data, v.exp_data);
    check("resp_wr_en_low", DW'(o_mem_wr_en), '0);
    i_rsp_ready = oh;
    @(posedge i_clk); #1;
    i_rsp_ready = '0;
    check("after_accept_valid", DW'(o_rsp_valid), '0);
    check("after_accept_data", o_rsp_data, '0);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    i_req_valid = '0;
    i_rsp_ready = '0;
    @(posedge i_clk); @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ready"}, DW'(o_req_ready), '0);
    check({tag, "_rsp_valid"}, DW'(o_rsp_valid), '0);
    check({tag, "_rsp_data"}, o_rsp_data, '0);
    check({tag, "_rsp_err"}, DW'(o_rsp_err), '0);
    check({tag, "_addr_w"}, DW'(o_mem_addr_w), '0);
    check({tag, "_data_w"}, o_mem_data_w, '0);
    check({tag, "_wr_size"}, DW'(o_mem_wr_size), '0);
    check({tag, "_wr_en"}, DW'(o_mem_wr_en), '0);
    check({tag, "_addr_r"}, DW'(o_mem_addr_r), '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // id, we, addr, size, seed, exp_err, exp_wr, exp_wsize, chk_ar, exp_ar, exp_data
    vecs[0]  = '{0, 1'b1, 24'h10, 3'd5, 32'hA, 1'b0, 1'b1, 3'd5, 1'b0, 24'h0, '0};
    vecs[1]  = '{0, 1'b0, 24'h10, 3'd0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b1, 24'h10, blk(32'hA)};
    vecs[2]  = '{1, 1'b1, 24'(DEPTH-5), 3'd5, 32'd100, 1'b0, 1'b1, 3'd5, 1'b0, 24'h0, '0};
    vecs[3]  = '{1, 1'b0, 24'(DEPTH-5), 3'd0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b1, 24'(DEPTH-5), blk(32'd100)};
    vecs[4]  = '{2, 1'b0, 24'(DEPTH-4), 3'd0, 32'h0, 1'b1, 1'b0, 3'd0, 1'b1, 24'(DEPTH-5), '0};
    vecs[5]  = '{3, 1'b1, 24'(DEPTH-2), 3'd2, 32'd200, 1'b0, 1'b1, 3'd2, 1'b0, 24'h0, '0};
    vecs[6]  = '{3, 1'b1, 24'(DEPTH-2), 3'd3, 32'd400, 1'b1, 1'b0, 3'd0, 1'b0, 24'h0, '0};
    vecs[7]  = '{2, 1'b0, 24'(DEPTH-5), 3'd0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b1, 24'(DEPTH-5),
                 {32'd100, 32'd101, 32'd102, 32'd200, 32'd201}};
    vecs[8]  = '{0, 1'b1, 24'h20, 3'd0, 32'd500, 1'b0, 1'b0, 3'd0, 1'b0, 24'h0, '0};
    vecs[9]  = '{0, 1'b0, 24'h20, 3'd0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b1, 24'h20, '0};
    vecs[10] = '{1, 1'b1, 24'h30, 3'd7, 32'd300, 1'b0, 1'b1, 3'd5, 1'b0, 24'h0, '0};
    vecs[11] = '{1, 1'b0, 24'h30, 3'd0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b1, 24'h30, blk(32'd300)};

    // Reset state
    @(posedge i_clk); #1;
    check_outputs_zero("reset");
    do_reset();
    #1;
    check_outputs_zero("post_reset");

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Round-robin fairness with all requesters continuously valid
    do_reset();
    for (int k = 0; k < N_REQ; k++) set_req(k, 1'b0, 24'h0, 3'd0, '0);
    i_req_valid = '1;
    i_rsp_ready = '1;
    #1;
    for (int g = 0; g < 6; g++) begin
      n = 0;
      while (o_req_ready == '0 && n < 10) begin
        @(posedge i_clk); #1;
        n++;
      end
      check("rr_grant", DW'(o_req_ready), DW'(N_REQ'(1) << (g % N_REQ)));
      @(posedge i_clk); #1;
    end
    i_req_valid = '0;
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rsp_ready = '0;
    check("rr_drained", DW'(o_rsp_valid), '0);

    // Response backpressure on requester 2 (pointer now at 1)
    @(negedge i_clk);
    set_req(2, 1'b0, 24'h10, 3'd0, '0);
    set_req(0, 1'b0, 24'h0, 3'd0, '0);
    i_req_valid = 4'b0100;
    #1;
    check("bp_grant", DW'(o_req_ready), DW'(4'b0100));
    @(posedge i_clk); #1;
    i_req_valid = 4'b0001;
    i_rsp_ready = 4'b1011;
    @(posedge i_clk); #1;
    for (int c = 0; c < 10; c++) begin
      check("bp_valid", DW'(o_rsp_valid), DW'(4'b0100));
      check("bp_data", o_rsp_data, blk(32'hA));
      check("bp_err", DW'(o_rsp_err), '0);
      check("bp_no_ready", DW'(o_req_ready), '0);
      @(posedge i_clk); #1;
    end
    i_rsp_ready = 4'b0100;
    @(posedge i_clk); #1;
    i_rsp_ready = '0;
    check("bp_accept_valid", DW'(o_rsp_valid), '0);
    check("bp_next_grant", DW'(o_req_ready), DW'(4'b0001));
    i_req_valid = '0;
    #1;
    check("drop_valid_ready", DW'(o_req_ready), '0);
    repeat (3) @(posedge i_clk);
    #1;
    check("drop_valid_nothing_latched", DW'(o_rsp_valid), '0);

    // Reset during ISSUE of a write
    @(negedge i_clk);
    set_req(1, 1'b1, 24'h40, 3'd5, blk(32'd700));
    i_req_valid = 4'b0010;
    @(posedge i_clk); #1;
    i_req_valid = '0;
    check("mid_issue_wr_en", DW'(o_mem_wr_en), DW'(1'b1));
    i_rst = 1'b1;
    #1;
    check("mid_reset_wr_gated", DW'(o_mem_wr_en), '0);
    @(posedge i_clk); #1;
    check_outputs_zero("mid_reset");
    i_rst = 1'b0;
    set_req(0, 1'b0, 24'h0, 3'd0, '0);
    set_req(3, 1'b0, 24'h0, 3'd0, '0);
    i_req_valid = 4'b1001;
    #1;
    check("post_reset_priority", DW'(o_req_ready), DW'(4'b0001));
    i_req_valid = '0;
    check("mid_reset_no_write", DW'(mem[24'h40]), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
